// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/flag bundle between the producer/consumer side, the
// FIFO control block and the storage memory.
//   master : drives push/data_in/pop and the almost thresholds, observes the rest
//   slave  : the FIFO controller; returns memory strobes, occupancy and flags
interface fifo_ctrl_if #(
  parameter int unsigned MEM_WIDTH = 10,
  parameter int unsigned ADDR_W    = 3
);

  // Requests and thresholds
  logic                 push;
  logic [MEM_WIDTH-1:0] data_in;
  logic                 pop;
  logic [ADDR_W:0]      almost_full_th;
  logic [ADDR_W:0]      almost_empty_th;

  // Memory strobes
  logic [MEM_WIDTH-1:0] Fifo_Data_in;
  logic                 write_enable;
  logic [ADDR_W-1:0]    write_addr;
  logic                 read_enable;
  logic [ADDR_W-1:0]    read_addr;

  // Status
  logic                 data_valid;
  logic [ADDR_W:0]      count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 error;

  modport master (
    output push, data_in, pop, almost_full_th, almost_empty_th,
    input  Fifo_Data_in, write_enable, write_addr, read_enable, read_addr,
    input  data_valid, count, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  push, data_in, pop, almost_full_th, almost_empty_th,
    output Fifo_Data_in, write_enable, write_addr, read_enable, read_addr,
    output data_valid, count, full, empty, almost_full, almost_empty, error
  );

endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control end of the FIFO storage array. Converts push/pop requests
// into memory write/read strobes, owns the read/write pointers, the occupancy
// count, full/empty/almost flags, a sticky overflow/underflow error and a
// data_valid flag aligned with the memory's registered read data.
// Ports:
//   clk    : single clock, all state on posedge
//   reset  : synchronous, active-high; clears pointers, count, error, data_valid
//   bus    : fifo_ctrl_if.slave (requests, thresholds, memory strobes, status)
module fifo_ctrl #(
  parameter int unsigned MEM_WIDTH  = 10,
  parameter int unsigned MEM_LENGHT = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 data_valid_q, data_valid_d;
  logic                 error_q, error_d;

  logic                 empty_c;
  logic                 full_c;
  logic                 pop_ok_c;
  logic                 push_ok_c;
  logic                 overflow_c;
  logic                 underflow_c;
  logic [MEM_WIDTH-1:0] wdata_c;

  // Acceptance and next-state; a full FIFO still accepts a push when a pop
  // frees a slot in the same cycle, an empty FIFO never bypasses push to pop.
  always_comb begin
    empty_c      = (count_q == '0);
    full_c       = (count_q == CNT_W'(MEM_LENGHT));
    pop_ok_c     = bus.pop & ~empty_c & ~reset;
    push_ok_c    = bus.push & (~full_c | pop_ok_c) & ~reset;
    overflow_c   = bus.push & full_c & ~(bus.pop & ~empty_c);
    underflow_c  = bus.pop & empty_c;

    wr_ptr_d     = wr_ptr_q + ADDR_W'(push_ok_c);
    rd_ptr_d     = rd_ptr_q + ADDR_W'(pop_ok_c);
    count_d      = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    data_valid_d = pop_ok_c;
    error_d      = error_q | overflow_c | underflow_c;
  end

  // State registers; reset dominates any request in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
    end
  end

  // Write data passes straight through to the memory
  assign wdata_c          = bus.data_in;
  assign bus.Fifo_Data_in = wdata_c;

  assign bus.write_enable = push_ok_c;
  assign bus.write_addr   = wr_ptr_q;
  assign bus.read_enable  = pop_ok_c;
  assign bus.read_addr    = rd_ptr_q;

  // Flags decode the registered count; thresholds are re-evaluated every cycle
  assign bus.data_valid   = data_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= bus.almost_full_th);
  assign bus.almost_empty = (count_q <= bus.almost_empty_th);
  assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a small behavioural memory
// holding the words so read order and one-cycle read latency can be checked.
module tb_fifo_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  fifo_ctrl_if #(.MEM_WIDTH(10), .ADDR_W(3)) bus ();

  fifo_ctrl #(.MEM_WIDTH(10), .MEM_LENGHT(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Storage array stand-in: registered read, read-before-write on same address
  logic [9:0] mem [8];
  logic [9:0] mem_rd;
  always @(posedge clk) begin
    if (bus.write_enable) mem[bus.write_addr] <= bus.Fifo_Data_in;
    if (bus.read_enable)  mem_rd <= mem[bus.read_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ps, input logic [9:0] d, input logic pp);
    bus.push    = ps;
    bus.data_in = d;
    bus.pop     = pp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    bus.almost_full_th  = 4'd6;
    bus.almost_empty_th = 4'd1;

    // Reset: strobes blocked even with requests present
    drive(1'b1, 10'h3FF, 1'b1);
    check("rst_we", 32'(bus.write_enable), 0);
    check("rst_re", 32'(bus.read_enable), 0);
    tick();
    tick();
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_ae", 32'(bus.almost_empty), 1);
    check("rst_af", 32'(bus.almost_full), 0);
    check("rst_err", 32'(bus.error), 0);
    check("rst_dv", 32'(bus.data_valid), 0);
    reset = 1'b0;
    drive(1'b0, 10'h000, 1'b0);
    tick();

    // Fill with 0x001..0x008
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'(i + 1), 1'b0);
      check("fill_we", 32'(bus.write_enable), 1);
      check("fill_addr", 32'(bus.write_addr), 32'(i));
      check("fill_data", 32'(bus.Fifo_Data_in), 32'(i + 1));
      check("fill_af", 32'(bus.almost_full), 32'(i >= 6));
      check("fill_ae", 32'(bus.almost_empty), 32'(i <= 1));
      tick();
    end
    drive(1'b0, 10'h000, 1'b0);
    check("full_count", 32'(bus.count), 8);
    check("full_full", 32'(bus.full), 1);
    check("full_af", 32'(bus.almost_full), 1);
    check("full_empty", 32'(bus.empty), 0);
    check("full_err", 32'(bus.error), 0);
    drive(1'b1, 10'h0FF, 1'b0);
    check("ovf_we", 32'(bus.write_enable), 0);
    tick();
    drive(1'b0, 10'h000, 1'b0);
    check("ovf_err", 32'(bus.error), 1);
    check("ovf_count", 32'(bus.count), 8);
    check("ovf_waddr", 32'(bus.write_addr), 0);

    // Drain: one word per cycle, valid one cycle after each pop
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 10'h000, 1'b1);
      check("drain_re", 32'(bus.read_enable), 1);
      check("drain_addr", 32'(bus.read_addr), 32'(i));
      tick();
      check("drain_dv", 32'(bus.data_valid), 1);
      check("drain_data", 32'(mem_rd), 32'(i + 1));
      check("drain_count", 32'(bus.count), 32'(7 - i));
    end
    drive(1'b0, 10'h000, 1'b0);
    check("drain_empty", 32'(bus.empty), 1);
    bus.almost_full_th = 4'd0;
    #1;
    check("th0_af", 32'(bus.almost_full), 1);
    bus.almost_full_th = 4'd6;
    #1;
    check("th6_af", 32'(bus.almost_full), 0);

    // Clear error, then underflow
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("clr_err", 32'(bus.error), 0);
    drive(1'b0, 10'h000, 1'b1);
    check("udf_re", 32'(bus.read_enable), 0);
    tick();
    drive(1'b0, 10'h000, 1'b0);
    check("udf_err", 32'(bus.error), 1);
    check("udf_dv", 32'(bus.data_valid), 0);
    check("udf_count", 32'(bus.count), 0);
    check("udf_raddr", 32'(bus.read_addr), 0);

    // Pointer wrap: push 6, pop 6, push 5, pop 5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 10'(32'h040 + i), 1'b0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 10'h000, 1'b1);
      tick();
      check("w6_data", 32'(mem_rd), 32'h040 + 32'(i));
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 10'(32'h0A0 + k), 1'b0);
      check("wrap_waddr", 32'(bus.write_addr), 32'((6 + k) % 8));
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 10'h000, 1'b1);
      check("wrap_raddr", 32'(bus.read_addr), 32'((6 + k) % 8));
      tick();
      check("wrap_dv", 32'(bus.data_valid), 1);
      check("wrap_data", 32'(mem_rd), 32'h0A0 + 32'(k));
    end
    drive(1'b0, 10'h000, 1'b0);
    check("wrap_rptr", 32'(bus.read_addr), 3);
    check("wrap_count", 32'(bus.count), 0);
    check("wrap_err", 32'(bus.error), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'(32'h100 + i), 1'b0);
      tick();
    end
    drive(1'b1, 10'h1FF, 1'b1);
    check("fpp_we", 32'(bus.write_enable), 1);
    check("fpp_re", 32'(bus.read_enable), 1);
    tick();
    check("fpp_count", 32'(bus.count), 8);
    check("fpp_full", 32'(bus.full), 1);
    check("fpp_err", 32'(bus.error), 0);
    check("fpp_data", 32'(mem_rd), 32'h100);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 10'h000, 1'b1);
      tick();
      check("fpp_drain", 32'(mem_rd), (i < 7) ? 32'h101 + 32'(i) : 32'h1FF);
    end
    drive(1'b0, 10'h000, 1'b0);
    check("fpp_empty", 32'(bus.empty), 1);

    // Empty with simultaneous push and pop: only push accepted
    drive(1'b1, 10'h055, 1'b1);
    check("epp_we", 32'(bus.write_enable), 1);
    check("epp_re", 32'(bus.read_enable), 0);
    tick();
    check("epp_count", 32'(bus.count), 1);
    check("epp_err", 32'(bus.error), 1);
    check("epp_dv", 32'(bus.data_valid), 0);

    // Mid-stream reset at count 5 with a read in flight
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'(32'h060 + i), 1'b0);
      tick();
    end
    drive(1'b0, 10'h000, 1'b1);
    tick();
    check("pre_count", 32'(bus.count), 5);
    check("pre_dv", 32'(bus.data_valid), 1);
    reset = 1'b1;
    drive(1'b1, 10'h077, 1'b0);
    check("mrst_we", 32'(bus.write_enable), 0);
    tick();
    reset = 1'b0;
    drive(1'b0, 10'h000, 1'b0);
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_empty", 32'(bus.empty), 1);
    check("mrst_waddr", 32'(bus.write_addr), 0);
    check("mrst_raddr", 32'(bus.read_addr), 0);
    check("mrst_err", 32'(bus.error), 0);
    check("mrst_dv", 32'(bus.data_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
